// File: rtl/maxpool_index_writer.sv
`default_nettype none
// ============================================================================
// Module      : maxpool_index_writer
// Description : Consumes 2x2 binary activation windows, emits the pooled bit
//               (OR of the window) and packs the argmax index of each window
//               MSB-first into words written to the pooling-index SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module maxpool_index_writer #(
  parameter int  IDX_WIDTH     = 2,
  parameter int  WR_DATA_WIDTH = 4,
  parameter int  WR_DATA_DEPTH = 65536,
  localparam int WR_ADDR_WIDTH = $clog2(WR_DATA_DEPTH),
  localparam int LANES         = WR_DATA_WIDTH / IDX_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [WR_ADDR_WIDTH-1:0] base_addr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               win,
  input  logic                     in_last,
  output logic                     pool_valid,
  output logic                     pool_out,
  output logic                     wr,
  output logic [WR_ADDR_WIDTH-1:0] wr_addr,
  output logic [WR_DATA_WIDTH-1:0] data_in,
  output logic [WR_ADDR_WIDTH:0]   word_count,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [WR_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LANE_W-1:0]        lane_q, lane_d;
  logic [WR_DATA_WIDTH-1:0] pack_q, pack_d;
  logic [WR_ADDR_WIDTH:0]   word_count_q, word_count_d;
  logic                     overflow_q, overflow_d;
  logic                     pool_valid_q, pool_valid_d;
  logic                     pool_out_q, pool_out_d;
  logic                     wr_q, wr_d;
  logic [WR_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [WR_DATA_WIDTH-1:0] data_in_q, data_in_d;
  logic                     done_q, done_d;

  logic [IDX_WIDTH-1:0]     idx;
  logic [WR_DATA_WIDTH-1:0] merged;
  logic                     accept;
  logic                     emit;

  assign accept = (state_q == RUN) && in_valid;
  assign emit   = accept && ((lane_q == LANE_W'(LANES - 1)) || in_last);

  // Argmax = lowest set position; merge it into the current lane of the word
  always_comb begin
    idx = '0;
    if      (win[0]) idx = IDX_WIDTH'(0);
    else if (win[1]) idx = IDX_WIDTH'(1);
    else if (win[2]) idx = IDX_WIDTH'(2);
    else if (win[3]) idx = IDX_WIDTH'(3);
    merged = pack_q;
    for (int l = 0; l < LANES; l++) begin
      if (lane_q == LANE_W'(l)) begin
        merged[WR_DATA_WIDTH-1-l*IDX_WIDTH -: IDX_WIDTH] = idx;
      end
    end
  end

  // Next-state, packing and write-port logic
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    lane_d       = lane_q;
    pack_d       = pack_q;
    word_count_d = word_count_q;
    overflow_d   = overflow_q;
    pool_valid_d = 1'b0;
    pool_out_d   = pool_out_q;
    wr_d         = 1'b0;
    wr_addr_d    = wr_addr_q;
    data_in_d    = data_in_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d       = base_addr;
          lane_d       = '0;
          pack_d       = '0;
          word_count_d = '0;
          overflow_d   = 1'b0;
          state_d      = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          pool_valid_d = 1'b1;
          pool_out_d   = |win;
          if (emit) begin
            wr_d         = 1'b1;
            wr_addr_d    = addr_q;
            data_in_d    = merged;
            word_count_d = word_count_q + (WR_ADDR_WIDTH+1)'(1);
            lane_d       = '0;
            pack_d       = '0;
            // Non-power-of-two depths need an explicit wrap point
            if (addr_q == WR_ADDR_WIDTH'(WR_DATA_DEPTH - 1)) begin
              addr_d     = '0;
              overflow_d = 1'b1;
            end else begin
              addr_d     = addr_q + WR_ADDR_WIDTH'(1);
            end
          end else begin
            lane_d = lane_q + LANE_W'(1);
            pack_d = merged;
          end
          if (in_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // done is registered, so it pulses the cycle after the final write
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      lane_q       <= '0;
      pack_q       <= '0;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
      pool_valid_q <= 1'b0;
      pool_out_q   <= 1'b0;
      wr_q         <= 1'b0;
      wr_addr_q    <= '0;
      data_in_q    <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      lane_q       <= lane_d;
      pack_q       <= pack_d;
      word_count_q <= word_count_d;
      overflow_q   <= overflow_d;
      pool_valid_q <= pool_valid_d;
      pool_out_q   <= pool_out_d;
      wr_q         <= wr_d;
      wr_addr_q    <= wr_addr_d;
      data_in_q    <= data_in_d;
      done_q       <= done_d;
    end
  end

  assign in_ready   = (state_q == RUN);
  assign busy       = (state_q == RUN);
  assign pool_valid = pool_valid_q;
  assign pool_out   = pool_out_q;
  assign wr         = wr_q;
  assign wr_addr    = wr_addr_q;
  assign data_in    = data_in_q;
  assign word_count = word_count_q;
  assign done       = done_q;
  assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: doc/maxpool_index_writer.md
Name: maxpool_index_writer

Overview:
- Upstream neighbour of the pooling-index SRAM in the encoder path.
- Consumes one 2x2 binary activation window per handshake. Emits the pooled bit (OR of the window) and the argmax index of that window.
- Packs consecutive indices MSB-first into WR_DATA_WIDTH-bit words and drives the index SRAM write port (wr, wr_addr, data_in), one word per write.
- The decoder's unpooling stage later reads these indices back.

Parameters:
- IDX_WIDTH, 2, bits per pooling index (2x2 window gives 4 positions).
- WR_DATA_WIDTH, 4, SRAM write word width; must be an integer multiple of IDX_WIDTH.
- WR_DATA_DEPTH, 65536, SRAM write depth in words.
- WR_ADDR_WIDTH, $clog2(WR_DATA_DEPTH), localparam.
- LANES, WR_DATA_WIDTH/IDX_WIDTH, localparam; indices per word.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame.
- base_addr  in  WR_ADDR_WIDTH  first SRAM word address of the frame; sampled on start.
- in_valid  in  1  window valid.
- in_ready  out  1  window accepted when in_valid && in_ready.
- win  in  4  binary window; bit0=top-left, bit1=top-right, bit2=bottom-left, bit3=bottom-right.
- in_last  in  1  qualifies the final window of the frame.
- pool_valid  out  1  pooled bit valid.
- pool_out  out  1  pooled bit, |win.
- wr  out  1  SRAM write enable.
- wr_addr  out  WR_ADDR_WIDTH  SRAM write address.
- data_in  out  WR_DATA_WIDTH  SRAM write data.
- word_count  out  WR_ADDR_WIDTH+1  words written in the current or most recent frame.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the final write.
- overflow  out  1  sticky; the address wrapped during the frame.

Behaviour:
- States are IDLE, RUN and DONE.
- Reset: state IDLE. All of the following are 0: in_ready, pool_valid, pool_out, wr, wr_addr, data_in, word_count, busy, done, overflow, the lane counter and the pack register.
- IDLE:
  - in_ready=0; in_valid is ignored.
  - start causes: addr<=base_addr, lane<=0, pack<=0, word_count<=0, overflow<=0, then RUN.
- RUN:
  - in_ready=1 and busy=1. start is ignored.
  - Argmax is the lowest set bit position of win. win==0 gives index 0 and pool_out 0.
  - On accept, the index is placed in lane `lane`. Lane 0 occupies bits [WR_DATA_WIDTH-1 -: IDX_WIDTH]; later lanes are successively lower.
  - pool_valid/pool_out are registered one cycle after accept. pool_valid=0 otherwise.
- Word emit happens on an accept when lane==LANES-1 or in_last=1:
  - Next cycle: wr=1, data_in = packed word including this index, with unused lower lanes zero-padded, and wr_addr = current addr.
  - After the write: addr<=addr+1, word_count<=word_count+1, lane<=0, pack<=0.
  - Otherwise, on a non-emitting accept: lane<=lane+1.
- Address wrap: when addr==WR_DATA_DEPTH-1, the increment wraps addr to 0 and sets overflow=1. overflow holds until the next start or rst.
- in_last accept: state goes to DONE in the following cycle, concurrent with the final wr pulse.
- DONE: done=1 for exactly one cycle, in_ready=0, then IDLE.
- wr, wr_addr and data_in are registered. wr is high for exactly one cycle per word. wr_addr and data_in hold their values when wr=0.
- Back-to-back accepts are supported every cycle (full throughput, no bubbles). Maximum is one write per LANES accepts.
- rst mid-frame: the partial word is discarded, no write is issued and the state returns to IDLE.
- A frame of N windows produces ceil(N/LANES) writes.

Test Plan:
- Reset: assert rst 2 cycles with random inputs -> all outputs 0; in_ready=0 while IDLE, and in_valid pulses produce no pool_valid.
- Full words: start with base_addr=0x0010, then windows 0001, 0100, 0000, 1000 (last on 4th) -> pool_out 1,1,0,1; writes 4'b0010 @0x0010 and 4'b0011 @0x0011; word_count=2; done pulse one cycle after the 2nd wr.
- Partial flush: base 0x0000, windows 0010, 0110, 0100 (last on 3rd) -> writes 4'b0101 @0x0000 and 4'b1000 @0x0001; overflow=0.
- Wrap: base 0xFFFF, four windows all 1000 -> writes 4'b1111 @0xFFFF and 4'b1111 @0x0000; overflow=1 after the 1st write and cleared by the next start.
- Protocol: a start pulse during RUN is ignored (addr continues); in_valid gaps of 0-3 cycles between windows give identical data/addresses; back-to-back windows give one accept per cycle.
- Reset mid-frame: after 1 accepted window, assert rst -> no wr, state IDLE; a new frame from base 0x0100 writes its first word at 0x0100 with lane 0 populated first.
